mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between fetch_unit (instruction requester) and the load/store stage (data requester).
- One transaction outstanding at a time, with valid/ready request handshakes and a registered response return.
- A jump-driven `flush` discards a stale in-flight instruction response.
- Sits between the core pipeline and the unified memory model/controller.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter_grant_select.sv | 37 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int ADDR_WIDTH = WORD_SIZE;
    localparam int DATA_WIDTH = WORD_SIZE;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_INST,
        OWNER_DATA
    } arb_owner_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   byte_en;
    } mem_req_t;

    function automatic arb_owner_t other_owner(input arb_owner_t owner);
        return (owner == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between core pipeline, arbiter and memory.
// slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                  inst_req_valid;
    logic                  inst_req_ready;
    logic [ADDR_WIDTH-1:0] inst_req_address;
    logic                  inst_resp_valid;
    logic [DATA_WIDTH-1:0] inst_resp_data;

    logic                  data_req_valid;
    logic                  data_req_ready;
    logic                  data_req_write;
    logic [ADDR_WIDTH-1:0] data_req_address;
    logic [DATA_WIDTH-1:0] data_req_wdata;
    logic [BE_WIDTH-1:0]   data_req_byte_en;
    logic                  data_resp_valid;
    logic [DATA_WIDTH-1:0] data_resp_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_address;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [BE_WIDTH-1:0]   mem_req_byte_en;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_rdata;

    modport slave (
        input  inst_req_valid, inst_req_address,
        output inst_req_ready, inst_resp_valid, inst_resp_data,
        input  data_req_valid, data_req_write, data_req_address,
        input  data_req_wdata, data_req_byte_en,
        output data_req_ready, data_resp_valid, data_resp_rdata,
        output mem_req_valid, mem_req_write, mem_req_address,
        output mem_req_wdata, mem_req_byte_en,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport master (
        output inst_req_valid, inst_req_address,
        input  inst_req_ready, inst_resp_valid, inst_resp_data,
        output data_req_valid, data_req_write, data_req_address,
        output data_req_wdata, data_req_byte_en,
        input  data_req_ready, data_resp_valid, data_resp_rdata,
        input  mem_req_valid, mem_req_write, mem_req_address,
        input  mem_req_wdata, mem_req_byte_en,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_grant_select.sv
// Combinational grant policy for the memory port arbiter.
// ARB_ROUND_ROBIN_EN selects alternating grant on contention; default is data-over-inst.
module arb_grant_select
    import mem_port_arbiter_pkg::*;
(
    input  logic       inst_valid,
    input  logic       data_valid,
    input  arb_owner_t last_grant,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = inst_valid || data_valid;
        grant_owner = OWNER_INST;
        if (inst_valid && data_valid) begin
            grant_owner = other_owner(last_grant);
        end else if (data_valid) begin
            grant_owner = OWNER_DATA;
        end
    end
`else
    // History is tracked by the top either way; fixed priority ignores it.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWNER_DATA);

    always_comb begin
        grant_valid = inst_valid || data_valid;
        grant_owner = OWNER_INST;
        if (data_valid) begin
            grant_owner = OWNER_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction in flight; optional round-robin contention policy via ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic flush,
    mem_port_arbiter_if.slave bus
);

    arb_state_t            state;
    arb_owner_t            owner;
    arb_owner_t            last_grant;
    logic                  drop;
    mem_req_t              req_q;
    logic                  mem_req_valid_q;
    logic                  inst_resp_valid_q;
    logic [DATA_WIDTH-1:0] inst_resp_data_q;
    logic                  data_resp_valid_q;
    logic [DATA_WIDTH-1:0] data_resp_rdata_q;

    logic                  grant_valid;
    arb_owner_t            grant_owner;
    logic                  inst_accept;
    logic                  data_accept;
    logic                  flush_inst;

    arb_grant_select u_grant_select (
        .inst_valid  (bus.inst_req_valid),
        .data_valid  (bus.data_req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign inst_accept = (state == ARB_IDLE) && grant_valid &&
                         (grant_owner == OWNER_INST) && bus.inst_req_valid;
    assign data_accept = (state == ARB_IDLE) && grant_valid &&
                         (grant_owner == OWNER_DATA) && bus.data_req_valid;
    assign flush_inst  = flush && (owner == OWNER_INST);

    assign bus.inst_req_ready  = inst_accept;
    assign bus.data_req_ready  = data_accept;
    assign bus.inst_resp_valid = inst_resp_valid_q;
    assign bus.inst_resp_data  = inst_resp_data_q;
    assign bus.data_resp_valid = data_resp_valid_q;
    assign bus.data_resp_rdata = data_resp_rdata_q;
    assign bus.mem_req_valid   = mem_req_valid_q;
    assign bus.mem_req_write   = req_q.write;
    assign bus.mem_req_address = req_q.address;
    assign bus.mem_req_wdata   = req_q.wdata;
    assign bus.mem_req_byte_en = req_q.byte_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= ARB_IDLE;
            owner             <= OWNER_INST;
            last_grant        <= OWNER_INST;
            drop              <= 1'b0;
            req_q             <= '0;
            mem_req_valid_q   <= 1'b0;
            inst_resp_valid_q <= 1'b0;
            inst_resp_data_q  <= '0;
            data_resp_valid_q <= 1'b0;
            data_resp_rdata_q <= '0;
        end else begin
            inst_resp_valid_q <= 1'b0;
            data_resp_valid_q <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    drop <= 1'b0;
                    if (data_accept) begin
                        req_q.write     <= bus.data_req_write;
                        req_q.address   <= bus.data_req_address;
                        req_q.wdata     <= bus.data_req_wdata;
                        req_q.byte_en   <= bus.data_req_byte_en;
                        owner           <= OWNER_DATA;
                        last_grant      <= OWNER_DATA;
                        mem_req_valid_q <= 1'b1;
                        state           <= ARB_ISSUE;
                    end else if (inst_accept) begin
                        req_q.write     <= 1'b0;
                        req_q.address   <= bus.inst_req_address;
                        req_q.wdata     <= '0;
                        req_q.byte_en   <= '1;
                        owner           <= OWNER_INST;
                        last_grant      <= OWNER_INST;
                        mem_req_valid_q <= 1'b1;
                        state           <= ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    if (flush_inst) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= ARB_WAIT_RESP;
                    end
                end

                ARB_WAIT_RESP: begin
                    if (flush_inst) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_resp_valid) begin
                        if (owner == OWNER_DATA) begin
                            data_resp_valid_q <= 1'b1;
                            data_resp_rdata_q <= req_q.write ? '0 : bus.mem_resp_rdata;
                        end else if (!(drop || flush_inst)) begin
                            // A flush arriving with the response still discards it.
                            inst_resp_valid_q <= 1'b1;
                            inst_resp_data_q  <= bus.mem_resp_rdata;
                        end
                        drop  <= 1'b0;
                        state <= ARB_IDLE;
                    end
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration and response rules.
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus variables, applied at the start of each cycle
    logic        iv, dv, dw, mrdy, mrv, fl;
    logic [31:0] ia, da, dwd, mrd;
    logic [3:0]  dbe;

    // transaction-level model
    bit          m_busy, m_issued, m_data_owner, m_drop, m_last_data;
    logic        m_w;
    logic [31:0] m_a, m_wd;
    logic [3:0]  m_be;
    bit          e_ip, e_dp;
    logic [31:0] e_id, e_dd;
    bit          acc_i, acc_d, obs_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        iv = 0; dv = 0; dw = 0; mrdy = 0; mrv = 0; fl = 0;
        ia = '0; da = '0; dwd = '0; mrd = '0; dbe = '0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_issued = 0; m_data_owner = 0; m_drop = 0; m_last_data = 0;
        m_w = 0; m_a = '0; m_wd = '0; m_be = '0;
        e_ip = 0; e_dp = 0; e_id = '0; e_dd = '0;
    endtask

    // Entered at posedge+1, leaves at the next posedge+1.
    task automatic cycle();
        bit exp_mrv, g_i, g_d, pref_i;
        bus.inst_req_valid   = iv;
        bus.inst_req_address = ia;
        bus.data_req_valid   = dv;
        bus.data_req_write   = dw;
        bus.data_req_address = da;
        bus.data_req_wdata   = dwd;
        bus.data_req_byte_en = dbe;
        bus.mem_req_ready    = mrdy;
        bus.mem_resp_valid   = mrv;
        bus.mem_resp_rdata   = mrd;
        flush                = fl;
        #1;

        check_eq("inst_resp_valid", bus.inst_resp_valid, e_ip);
        if (e_ip) check_eq("inst_resp_data", bus.inst_resp_data, e_id);
        check_eq("data_resp_valid", bus.data_resp_valid, e_dp);
        if (e_dp) check_eq("data_resp_rdata", bus.data_resp_rdata, e_dd);

        exp_mrv = m_busy && !m_issued;
        check_eq("mem_req_valid", bus.mem_req_valid, exp_mrv);
        if (exp_mrv) begin
            check_eq("mem_req_write", bus.mem_req_write, m_w);
            check_eq("mem_req_address", bus.mem_req_address, m_a);
            check_eq("mem_req_wdata", bus.mem_req_wdata, m_wd);
            check_eq("mem_req_byte_en", bus.mem_req_byte_en, m_be);
        end

`ifdef ARB_ROUND_ROBIN_EN
        pref_i = m_last_data;
`else
        pref_i = 1'b0;
`endif
        g_i = !m_busy && iv && (!dv || pref_i);
        g_d = !m_busy && dv && !g_i;
        check_eq("inst_req_ready", bus.inst_req_ready, g_i);
        check_eq("data_req_ready", bus.data_req_ready, g_d);
        obs_i = bus.inst_req_ready;
        acc_i = g_i;
        acc_d = g_d;

        e_ip = 0;
        e_dp = 0;
        if (g_i) begin
            m_busy = 1; m_issued = 0; m_data_owner = 0; m_last_data = 0; m_drop = 0;
            m_w = 0; m_a = ia; m_wd = '0; m_be = 4'hF;
        end else if (g_d) begin
            m_busy = 1; m_issued = 0; m_data_owner = 1; m_last_data = 1; m_drop = 0;
            m_w = dw; m_a = da; m_wd = dwd; m_be = dbe;
        end else if (m_busy) begin
            if (fl && !m_data_owner) m_drop = 1;
            if (!m_issued) begin
                if (mrdy) m_issued = 1;
            end else if (mrv) begin
                m_busy = 0;
                m_issued = 0;
                if (m_data_owner) begin
                    e_dp = 1;
                    e_dd = m_w ? 32'h0 : mrd;
                end else if (!m_drop) begin
                    e_ip = 1;
                    e_id = mrd;
                end
            end
        end

        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int n);
        drive_idle();
        repeat (n) cycle();
    endtask

    int b2b_cnt;

    initial begin
        drive_idle();
        model_reset();
        bus.inst_req_valid = 0; bus.data_req_valid = 0; bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0; bus.inst_req_address = '0; bus.data_req_address = '0;
        bus.data_req_write = 0; bus.data_req_wdata = '0; bus.data_req_byte_en = '0;
        bus.mem_resp_rdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_mem_req_valid", bus.mem_req_valid, 0);
        check_eq("reset_mem_req_address", bus.mem_req_address, 0);
        check_eq("reset_mem_req_byte_en", bus.mem_req_byte_en, 0);
        check_eq("reset_inst_resp_valid", bus.inst_resp_valid, 0);
        check_eq("reset_data_resp_valid", bus.data_resp_valid, 0);
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
        drain(2);

        // fetch only
        iv = 1; ia = 32'h0000_0040; mrdy = 1;
        cycle();
        iv = 0;
        cycle();
        mrv = 1; mrd = 32'h3657_3475;
        cycle();
        mrv = 0;
        cycle();
        drain(2);

        // contention, then a second contention as the data response returns
        iv = 1; ia = 32'h80; dv = 1; dw = 0; da = 32'h100; mrdy = 1;
        cycle();
        if (acc_d) dv = 0;
        cycle();
        mrv = 1; mrd = $urandom;
        cycle();
        dv = 1; da = 32'h104; mrv = 1; mrd = $urandom;
        repeat (12) begin
            cycle();
            if (acc_i) iv = 0;
            if (acc_d) dv = 0;
            mrd = $urandom;
        end
        drain(3);

        // store with wait states
        dv = 1; dw = 1; da = 32'h200; dwd = 32'hDEAD_BEEF; dbe = 4'b0011; mrdy = 0;
        cycle();
        dv = 0;
        repeat (3) cycle();
        mrdy = 1;
        cycle();
        mrdy = 0; mrv = 1; mrd = $urandom | 32'h1;
        cycle();
        mrv = 0;
        cycle();
        drain(2);

        // flush during an instruction fetch
        iv = 1; ia = 32'h40; mrdy = 1;
        cycle();
        iv = 0;
        cycle();
        fl = 1;
        cycle();
        fl = 0; mrv = 1; mrd = 32'h1234_5678;
        cycle();
        mrv = 0;
        cycle();
        drain(2);

        // flush during a data load
        dv = 1; dw = 0; da = 32'h300; mrdy = 1;
        cycle();
        dv = 0; fl = 1;
        cycle();
        mrv = 1; mrd = 32'hCAFE_0001;
        cycle();
        fl = 0; mrv = 0;
        cycle();
        drain(2);

        // reset in the middle of an issue
        iv = 1; ia = 32'h44; mrdy = 0;
        cycle();
        iv = 0;
        bus.inst_req_valid = 0;
        check_eq("issue_mem_req_valid", bus.mem_req_valid, 1);
        #2;
        reset = 0;
        #1;
        check_eq("async_rst_mem_req_valid", bus.mem_req_valid, 0);
        check_eq("async_rst_mem_req_address", bus.mem_req_address, 0);
        check_eq("async_rst_mem_req_byte_en", bus.mem_req_byte_en, 0);
        check_eq("async_rst_inst_req_ready", bus.inst_req_ready, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
        mrv = 1; mrd = 32'h5555_AAAA;
        cycle();
        mrv = 0;
        cycle();
        drain(2);

        // back-to-back fetches
        iv = 1; ia = 32'h1000; mrdy = 1; mrv = 1;
        b2b_cnt = 0;
        repeat (12) begin
            mrd = $urandom;
            cycle();
            if (obs_i) b2b_cnt++;
            ia = ia + 4;
        end
        check_eq("b2b_accept_count", b2b_cnt, 4);
        iv = 0;
        repeat (3) cycle();
        drain(2);

        // randomized traffic
        repeat (2000) begin
            if (!iv && ($urandom % 3 == 0)) begin
                iv = 1; ia = $urandom;
            end
            if (!dv && ($urandom % 4 == 0)) begin
                dv = 1; dw = 1'($urandom % 2); da = $urandom; dwd = $urandom; dbe = 4'($urandom);
            end
            mrdy = 1'($urandom % 2);
            mrv  = m_issued ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
            mrd  = $urandom;
            fl   = ($urandom % 8 == 0);
            cycle();
            if (acc_i) iv = 0;
            if (acc_d) dv = 0;
        end
        iv = 0; dv = 0; fl = 0; mrdy = 1; mrv = 1;
        repeat (4) begin
            mrd = $urandom;
            cycle();
        end
        drain(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
